real2pwl_mc: RTL
================

Name: real2pwl_mc

Overview:
- Clocked, multi-channel successor to the single-channel pwc-to-pwl converter.
- Each channel accepts real target values through a valid/ready handshake and buffers them in a per-channel FIFO.
- Each channel drives a pwl output that ramps linearly from its present value to each target over a programmable number of clock cycles.
- Sits between discrete-time real-valued behavioural models (DAC codes, regulator setpoints) and pwl-consuming analog models.

Parameters:
- NCH, 4, number of independent channels (1..32).
- DEPTH, 4, per-channel target FIFO depth (power of 2, >=2).
- TR_CYC, 4, ramp length in clock cycles; 0 = step mode (slope always 0).
- TCLK, 1e-9, nominal clock period in seconds; used for slope computation.
- CNT_W, 8, ramp counter width; TR_CYC must be < 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rstb  input  1  asynchronous active-low reset.
- en  input  1  channel-group enable (act. Hi); pulled up when unconnected.
- in  input  real[NCH]  per-channel target value.
- in_valid  input  NCH  per-channel target valid.
- in_ready  output  NCH  per-channel FIFO not full.
- out  output  pwl[NCH]  per-channel pwl output {a, b, t0}.
- busy  output  NCH  channel ramping or FIFO non-empty.
- cur_val  output  real[NCH]  value the channel holds or is heading to (last committed target).

Behaviour:
- Reset (rstb=0, async):
  - out[i]={0,0,0}, cur_val=0, busy=0, in_ready=1.
  - FIFO empty, state IDLE, counter 0.
  - Reset mid-ramp aborts immediately; no further pwl writes until rstb=1 and a clk edge.
- en=0, sampled at clk:
  - All channels: out={0,0,t_now}, FIFOs flushed, state IDLE, cur_val=0, in_ready=1, busy=0.
  - in_valid is ignored while en=0.
- Push:
  - At a clk edge with in_valid[i]&in_ready[i]&en, in[i] is written to FIFO i.
  - in_ready is computed from the registered count only. A full FIFO rejects a push even when a pop occurs on the same edge.
- Per-channel FSM, states IDLE and RAMP, evaluated at each clk edge after reset:
  - IDLE, FIFO empty: hold; no write to out.
  - IDLE, FIFO non-empty: pop target T. Let v0 = out value evaluated at t_now.
    - If T==v0 or TR_CYC==0: out={T,0,t_now}, stay IDLE.
    - Else: out={v0,(T-v0)/(TR_CYC*TCLK),t_now}, cnt=TR_CYC-1, go RAMP.
    - cur_val=T in both cases.
  - RAMP, cnt>0: cnt--; out unchanged.
  - RAMP, cnt==0: snap out={T,0,t_now} to remove slope rounding error.
    - If FIFO non-empty, pop the next target on the same edge and start the next ramp from T, with no idle cycle.
    - Otherwise go IDLE.
- Latency: a target pushed at edge k starts its ramp at edge k+1 if the channel is idle. The snap occurs at edge k+1+TR_CYC.
- Simultaneous push and pop on one channel with a non-full FIFO: both take effect; count is unchanged.
- Channels are fully independent. A push to one channel never affects another channel's timing.
- busy[i] = (state==RAMP) | (count!=0), registered.
- out is written only on the events listed above, never on every clock, to minimise pwl event traffic.

Test Plan:
- Reset/idle: rstb=0 then release, NCH=4 → all out={0,0,0}, in_ready=4'b1111, busy=0.
- Single ramp: TR_CYC=4, TCLK=1ns, push 1.0 on ch0 at edge 0 → edge 1: out[0]={0,2.5e8,t1}; edge 5: out[0]={1.0,0,t5}; busy falls after edge 5.
- Back-to-back queue: push 1.0, 0.5, 2.0 on consecutive edges → ramps 0→1→0.5→2.0 with no gaps; slopes 2.5e8, -1.25e8, 3.75e8; snaps at edges 5, 9, 13.
- FIFO full: DEPTH=4, push 6 values while ramping → in_ready[0]=0 after the 4th buffered entry; extra pushes dropped; all accepted values are emitted in order.
- Step mode / equal target: TR_CYC=0, push 0.7 → out={0.7,0,t} one edge later. With TR_CYC=4, pushing the current value → flat write, no RAMP.
- en/reset mid-ramp: drop en at edge 3 of a 0→1 ramp → out={0,0,t}, FIFO flushed. Assert rstb=0 mid-ramp → immediate {0,0,0} without a clock.

Source files
------------

// File: rtl/real2pwl_mc_if.sv
// Per-channel target handshake and pwl output bundle for real2pwl_mc.
// A pwl segment {a, b, t0} is carried as three parallel real arrays:
// value(t) = a + b * (t - t0), with t0 and t in seconds.
`timescale 1ns/1ps
interface real2pwl_mc_if #(
  parameter int NCH = 4
);
  real            in      [NCH];
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_ready;
  real            out_a   [NCH];
  real            out_b   [NCH];
  real            out_t0  [NCH];
  logic [NCH-1:0] busy;
  real            cur_val [NCH];

  modport master (
    output in, in_valid,
    input  in_ready, out_a, out_b, out_t0, busy, cur_val
  );

  modport slave (
    input  in, in_valid,
    output in_ready, out_a, out_b, out_t0, busy, cur_val
  );
endinterface

// File: rtl/real2pwl_mc.sv
// Multi-channel real-target to pwl converter. Each channel buffers targets
// in a FIFO and ramps its pwl output linearly to each target over TR_CYC
// clocks, snapping exactly onto the target when the ramp ends. The pwl
// output is written only when a segment starts, snaps, or is cleared.
// Timestamps come from simulation time; this file's time unit is 1 ns.
// The en input should be tied to 1'b1 when the group enable is not used.
`timescale 1ns/1ps
module real2pwl_mc #(
  parameter int  NCH    = 4,
  parameter int  DEPTH  = 4,
  parameter int  TR_CYC = 4,
  parameter real TCLK   = 1.0e-9,
  parameter int  CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          en,
  real2pwl_mc_if.slave  io
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, RAMP} state_t;

  state_t           state_q  [NCH];
  state_t           state_n  [NCH];
  logic [CW-1:0]    count_q  [NCH];
  logic [CW-1:0]    count_n  [NCH];
  logic [PW-1:0]    wr_ptr_q [NCH];
  logic [PW-1:0]    rd_ptr_q [NCH];
  logic [CNT_W-1:0] cnt_q    [NCH];
  logic [CNT_W-1:0] cnt_n    [NCH];
  real              mem      [NCH][DEPTH];
  real              head     [NCH];
  real              start_v  [NCH];
  real              tgt_q    [NCH];
  real              tgt_n    [NCH];
  real              out_a_q  [NCH];
  real              out_b_q  [NCH];
  real              out_t0_q [NCH];
  real              a_n      [NCH];
  real              b_n      [NCH];
  logic [NCH-1:0]   ready;
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;
  logic [NCH-1:0]   snap;
  logic [NCH-1:0]   flat;
  logic [NCH-1:0]   wr_out;
  logic [NCH-1:0]   busy_q;

  // Handshake, pop decision and next FSM state for every channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned (which would infer a latch).
      ready[i]   = 1'b1;
      push[i]    = 1'b0;
      pop[i]     = 1'b0;
      snap[i]    = 1'b0;
      flat[i]    = 1'b0;
      head[i]    = mem[i][rd_ptr_q[i]];
      start_v[i] = out_a_q[i];
      state_n[i] = state_q[i];
      count_n[i] = count_q[i];

      // Readiness depends on the registered count only, so a full FIFO
      // refuses a push even on an edge where it also pops.
      ready[i] = !en || (count_q[i] != CW'(DEPTH));
      push[i]  = en && io.in_valid[i] && ready[i];
      snap[i]  = (state_q[i] == RAMP) && (cnt_q[i] == '0);
      pop[i]   = en && (count_q[i] != '0) && ((state_q[i] == IDLE) || snap[i]);
      // In IDLE the slope is always zero, so the present value is out_a;
      // at a snap the next ramp starts from the target just reached.
      start_v[i] = snap[i] ? tgt_q[i] : out_a_q[i];
      flat[i]    = pop[i] && ((TR_CYC == 0) || (head[i] == start_v[i]));

      if (!en) begin
        state_n[i] = IDLE;
        count_n[i] = '0;
      end else begin
        if (pop[i] && !flat[i]) state_n[i] = RAMP;
        else if (snap[i])       state_n[i] = IDLE;
        count_n[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Output-side decisions: when to write out, with which segment, and the
  // ramp counter / committed target that go with it.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr_out[i] = 1'b0;
      a_n[i]    = out_a_q[i];
      b_n[i]    = out_b_q[i];
      cnt_n[i]  = cnt_q[i];
      tgt_n[i]  = tgt_q[i];

      if (!en) begin
        wr_out[i] = 1'b1;
        a_n[i]    = 0.0;
        b_n[i]    = 0.0;
        cnt_n[i]  = '0;
        tgt_n[i]  = 0.0;
      end else if (pop[i]) begin
        wr_out[i] = 1'b1;
        tgt_n[i]  = head[i];
        if (flat[i]) begin
          a_n[i]   = head[i];
          b_n[i]   = 0.0;
          cnt_n[i] = '0;
        end else begin
          a_n[i]   = start_v[i];
          b_n[i]   = (head[i] - start_v[i]) / (real'(TR_CYC) * TCLK);
          cnt_n[i] = CNT_W'(TR_CYC - 1);
        end
      end else if (snap[i]) begin
        // Land exactly on the target to drop accumulated slope rounding.
        wr_out[i] = 1'b1;
        a_n[i]    = tgt_q[i];
        b_n[i]    = 0.0;
      end else if (state_q[i] == RAMP) begin
        cnt_n[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < NCH; i++) state_q[i] <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking '<=' so every register samples
      // pre-edge values regardless of statement order.
      for (int i = 0; i < NCH; i++) state_q[i] <= state_n[i];
    end
  end

  // FIFO bookkeeping, ramp counter, committed target and pwl output registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < NCH; i++) begin
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        tgt_q[i]    <= 0.0;
        out_a_q[i]  <= 0.0;
        out_b_q[i]  <= 0.0;
        out_t0_q[i] <= 0.0;
        busy_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        count_q[i] <= count_n[i];
        cnt_q[i]   <= cnt_n[i];
        tgt_q[i]   <= tgt_n[i];
        busy_q[i]  <= (state_n[i] == RAMP) || (count_n[i] != '0);
        if (!en) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
        end else begin
          if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
          if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        end
        if (wr_out[i]) begin
          out_a_q[i]  <= a_n[i];
          out_b_q[i]  <= b_n[i];
          out_t0_q[i] <= $realtime * 1.0e-9;
        end
      end
    end
  end

  // FIFO storage write.
  // NOTE: the storage array has no reset; the count and pointers alone
  // decide which entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) mem[i][wr_ptr_q[i]] <= io.in[i];
    end
  end

  // Drive the interface outputs from the registers.
  always_comb begin
    io.in_ready = ready;
    io.busy     = busy_q;
    for (int i = 0; i < NCH; i++) begin
      io.out_a[i]   = out_a_q[i];
      io.out_b[i]   = out_b_q[i];
      io.out_t0[i]  = out_t0_q[i];
      io.cur_val[i] = tgt_q[i];
    end
  end

endmodule
